vector_alu_pipe: RTL and testbench

//  Multi-lane, two-stage pipelined vector ALU. Successor to the single-lane combinational

---
 rtl/vector_alu_pkg.sv | 18 +
 rtl/vector_alu_lane.sv | 44 ++++
 rtl/vector_alu_pipe.sv | 97 +++++++++
 tb/tb_vector_alu_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_alu_pkg.sv
// Shared opcodes and default geometry for the vector ALU pipeline.
package vector_alu_pkg;

  localparam int LANES_DEF = 4;
  localparam int EW_DEF    = 32;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD = 3'd0;
  localparam op_t OP_SUB = 3'd1;
  localparam op_t OP_MUL = 3'd2;
  localparam op_t OP_XOR = 3'd3;
  localparam op_t OP_OR  = 3'd4;
  localparam op_t OP_AND = 3'd5;
  localparam op_t OP_SLL = 3'd6;
  localparam op_t OP_SRL = 3'd7;

endpackage

// File: rtl/vector_alu_lane.sv
// Single-lane combinational ALU: unsigned EW-bit ops, masked lanes pass operand A through.
module vector_alu_lane
  import vector_alu_pkg::*;
#(
  parameter int EW  = 32,
  parameter int SHW = $clog2(EW)
) (
  input  op_t           sel,
  input  logic          mask,
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  output logic [EW-1:0] r,
  output logic          z,
  output logic          c
);

  logic [EW:0]     sum;
  logic [2*EW-1:0] prod;
  logic [EW-1:0]   r_op;
  logic            c_op;

  // Op select; carry/borrow/mul-overflow only meaningful for arithmetic ops.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    prod = {{EW{1'b0}}, a} * {{EW{1'b0}}, b};
    r_op = '0;
    c_op = 1'b0;
    case (sel)
      OP_ADD: begin r_op = sum[EW-1:0];  c_op = sum[EW];             end
      OP_SUB: begin r_op = a - b;        c_op = (a < b);             end
      OP_MUL: begin r_op = prod[EW-1:0]; c_op = |prod[2*EW-1:EW];    end
      OP_XOR: r_op = a ^ b;
      OP_OR:  r_op = a | b;
      OP_AND: r_op = a & b;
      OP_SLL: r_op = a << b[SHW-1:0];
      OP_SRL: r_op = a >> b[SHW-1:0];
      default: begin r_op = '0; c_op = 1'b0; end
    endcase
    r = mask ? r_op : a;
    c = mask & c_op;
    z = (r == '0);
  end

endmodule

// File: rtl/vector_alu_pipe.sv
// Two-stage vector ALU: S1 registers the operand bundle, S2 registers lane results and flags.
// Each stage holds while the stage after it is full and not draining.
module vector_alu_pipe
  import vector_alu_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int EW    = EW_DEF,
  parameter int SHW   = $clog2(EW)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          sel,
  input  logic [LANES-1:0]    mask,
  input  logic [LANES*EW-1:0] a,
  input  logic [LANES*EW-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*EW-1:0] result,
  output logic [LANES-1:0]    flag_z,
  output logic [LANES-1:0]    flag_c
);

  localparam int STAGES = 2;

  typedef struct packed {
    op_t                       sel;
    logic [LANES-1:0]          mask;
    logic [LANES-1:0][EW-1:0]  a;
    logic [LANES-1:0][EW-1:0]  b;
  } req_t;

  typedef struct packed {
    logic [LANES-1:0][EW-1:0]  result;
    logic [LANES-1:0]          z;
    logic [LANES-1:0]          c;
  } rsp_t;

  logic [STAGES:1] vld_pipe;
  req_t            s1_q;
  rsp_t            s2_q;
  rsp_t            lane_rsp;
  logic            s2_load;
  logic            s1_adv;
  logic            accept;

  // Stage handshake; in_ready deliberately independent of in_valid.
  always_comb begin
    s2_load  = !vld_pipe[2] || out_ready;
    s1_adv   = vld_pipe[1] && s2_load;
    in_ready = ena && (!vld_pipe[1] || s2_load);
    accept   = in_valid && in_ready;
  end

  // Valid bits: S1 fills on accept, empties when it advances; S2 takes S1's valid when loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (accept)      vld_pipe[1] <= 1'b1;
      else if (s1_adv) vld_pipe[1] <= 1'b0;
      if (s2_load)     vld_pipe[2] <= vld_pipe[1];
    end
  end

  // S1 operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      s1_q <= '0;
    else if (accept) s1_q <= '{sel: sel, mask: mask, a: a, b: b};
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vector_alu_lane #(.EW(EW), .SHW(SHW)) u_lane (
      .sel  (s1_q.sel),
      .mask (s1_q.mask[i]),
      .a    (s1_q.a[i]),
      .b    (s1_q.b[i]),
      .r    (lane_rsp.result[i]),
      .z    (lane_rsp.z[i]),
      .c    (lane_rsp.c[i])
    );
  end

  // S2 result capture; holds while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      s2_q <= '0;
    else if (s1_adv) s2_q <= lane_rsp;
  end

  assign out_valid = vld_pipe[2];
  assign result    = s2_q.result;
  assign flag_z    = s2_q.z;
  assign flag_c    = s2_q.c;

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Scoreboard bench for vector_alu_pipe: driver pushes model results, monitor pops on output transfer.
module tb_vector_alu_pipe;

  localparam int LANES = 4;
  localparam int EW    = 32;

  logic                clk = 1'b0;
  logic                rst_n, ena, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]          sel;
  logic [LANES-1:0]    mask;
  logic [LANES*EW-1:0] a, b, result;
  logic [LANES-1:0]    flag_z, flag_c;

  vector_alu_pipe #(.LANES(LANES), .EW(EW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mask(mask), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*EW-1:0] r;
    logic [LANES-1:0]    z;
    logic [LANES-1:0]    c;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   rnd_bp = 1'b0;
  bit   force_rdy = 1'b1;

  // Reference: plain 64-bit arithmetic per lane, reduced mod 2^32.
  function automatic exp_t model(input logic [2:0] op, input logic [LANES-1:0] m,
                                 input logic [LANES*EW-1:0] va, input logic [LANES*EW-1:0] vb);
    exp_t e;
    longint unsigned x, y, full;
    logic [31:0] rr;
    logic cc;
    for (int i = 0; i < LANES; i++) begin
      x  = 64'(va[i*EW +: EW]);
      y  = 64'(vb[i*EW +: EW]);
      cc = 1'b0;
      full = 64'd0;
      case (op)
        3'd0: begin full = x + y; rr = full[31:0]; cc = (full >> 32) != 0; end
        3'd1: begin rr = 32'(x - y); cc = (x < y); end
        3'd2: begin full = x * y; rr = full[31:0]; cc = (full >> 32) != 0; end
        3'd3: rr = 32'(x ^ y);
        3'd4: rr = 32'(x | y);
        3'd5: rr = 32'(x & y);
        3'd6: rr = 32'(x << (y % 32));
        default: rr = 32'(x >> (y % 32));
      endcase
      if (!m[i]) begin rr = 32'(x); cc = 1'b0; end
      e.r[i*EW +: EW] = rr;
      e.z[i] = (rr == 32'd0);
      e.c[i] = cc;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [LANES*EW-1:0] act, input logic [LANES*EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one bundle (called just after a posedge); push expectation on the accepting edge.
  task automatic send(input logic [2:0] op, input logic [LANES-1:0] m,
                      input logic [LANES*EW-1:0] va, input logic [LANES*EW-1:0] vb);
    int  n = 0;
    bit  fire;
    in_valid = 1'b1; sel = op; mask = m; a = va; b = vb;
    forever begin
      @(negedge clk);
      fire = in_ready;
      @(posedge clk);
      if (fire) begin
        sb.push_back(model(op, m, va, vb));
        break;
      end
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready never rose within 200 cycles");
        break;
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [LANES*EW-1:0] va, vb;
    for (int i = 0; i < LANES; i++) begin
      va[i*EW +: EW] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      vb[i*EW +: EW] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    end
    send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), va, vb);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end
    #1;
  endtask

  // Downstream ready: random backpressure or a forced level.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rnd_bp ? ($urandom_range(0, 3) != 0) : force_rdy;
    end
  end

  // Monitor: compare on each output transfer, verify outputs hold while stalled.
  initial begin
    exp_t e;
    bit stalled = 1'b0;
    logic [LANES*EW-1:0] held_r;
    logic [LANES-1:0] held_z, held_c;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        chk("hold_valid", 128'(out_valid), 128'd1);
        chk("hold_result", result, held_r);
        chk("hold_flags", 128'({flag_z, flag_c}), 128'({held_z, held_c}));
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got result %h expected no output", result);
          end else begin
            e = sb.pop_front();
            chk("result", result, e.r);
            chk("flag_z", 128'(flag_z), 128'(e.z));
            chk("flag_c", 128'(flag_c), 128'(e.c));
          end
        end else begin
          stalled = 1'b1;
          held_r = result; held_z = flag_z; held_c = flag_c;
        end
      end
    end
  end

  initial begin
    logic [LANES*EW-1:0] va, vb;
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b1;
    sel = 3'd0; mask = 4'hF; a = {4{32'h1234_5678}}; b = {4{32'h1}};
    #12;
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_result", result, 128'd0);
    chk("reset_flags", 128'({flag_z, flag_c}), 128'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Directed corner bundles.
    va = {3{$urandom}}; va = {va[95:0], 32'hFFFF_FFFF};
    vb = {96'd0, 32'd1};
    send(3'd0, 4'hF, va, vb);
    send(3'd1, 4'hF, {64'd0, 32'd5, 32'd0}, {64'd0, 32'd7, 32'd0});
    send(3'd2, 4'hF, {32'd0, 32'h1_0000, 64'd0}, {32'd0, 32'h1_0000, 64'd0});
    send(3'd0, 4'b0101, {4{32'd10}}, {4{32'd3}});
    send(3'd6, 4'hF, {4{32'h8000_0001}}, {32'd31, 32'd0, 32'd1, 32'd35});
    send(3'd7, 4'h0, {4{32'h0}}, {4{32'd2}});
    wait_empty();

    // Random stream with random backpressure.
    rnd_bp = 1'b1;
    repeat (80) send_rand();
    rnd_bp = 1'b0; force_rdy = 1'b1;
    wait_empty();

    // Backpressure: hold out_ready low while streaming 6 bundles.
    force_rdy = 1'b0;
    @(posedge clk);
    #1;
    fork
      repeat (6) send_rand();
      begin
        repeat (4) @(negedge clk);
        chk("bp_in_ready", 128'(in_ready), 128'd0);
        chk("bp_out_valid", 128'(out_valid), 128'd1);
        force_rdy = 1'b1;
      end
    join
    wait_empty();

    // ena=0 blocks acceptance while in-flight bundles drain.
    force_rdy = 1'b0;
    @(posedge clk);
    #1;
    send_rand();
    send_rand();
    ena = 1'b0; in_valid = 1'b1; force_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ena_in_ready", 128'(in_ready), 128'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0; ena = 1'b1;
    wait_empty();

    // Reset with two bundles in flight.
    force_rdy = 1'b0;
    @(posedge clk);
    #1;
    send_rand();
    send_rand();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_result", result, 128'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; force_rdy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("postrst_idle", 128'(out_valid), 128'd0);

    // Recovery after reset.
    repeat (4) send_rand();
    wait_empty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
